uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters, one frame at a time.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                   i_Clock,
   input  logic                   i_Rst_n,
   input  logic [NUM_REQ-1:0]     i_Req_DV,
   input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
   output logic [NUM_REQ-1:0]     o_Req_Ack,
   output logic [NUM_REQ-1:0]     o_Req_Done,
   output logic                   o_Tx_DV,
   output logic [7:0]             o_Tx_Byte,
   input  logic                   i_Tx_Active,
   input  logic                   i_Tx_Done,
   output logic [2:0]             o_Grant_Id,
   output logic                   o_Busy,
   output logic [2:0]             o_State
);

   // Handshake: requester k holds i_Req_DV[k] (valid) with its byte until o_Req_Ack[k] pulses;
   // the transmitter is only started (o_Tx_DV) while i_Tx_Active and i_Tx_Done are both low.

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ISSUE       = 3'd1,
      WAIT_ACTIVE = 3'd2,
      WAIT_DONE   = 3'd3,
      DRAIN       = 3'd4
   } state_t;

   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_next;
   logic [7:0]           tx_byte;
   logic [7:0]           tx_byte_next;
   logic [2:0]           grant_id;
   logic [2:0]           grant_id_next;
   logic [2:0]           winner;
   logic [7:0]           winner_byte;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic                 any_req;
   logic                 tx_idle;
   int                   cand;

   assign any_req      = |i_Req_DV;
   assign tx_idle      = !i_Tx_Active && !i_Tx_Done;
   assign grant_onehot = ONE << grant_id;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      winner = grant_id;
      cand   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef UART_ARB_FIXED_PRIO_EN
         cand = i;
`else
         cand = (int'(grant_id) + 1 + i) % NUM_REQ;
`endif
         if ((i_Req_DV & (ONE << cand)) != '0) begin
            winner = cand[2:0];
         end
      end
   end

   always_comb begin
      winner_byte = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winner == k[2:0]) begin
            winner_byte = i_Req_Byte[8*k +: 8];
         end
      end
   end

   always_comb begin
      state_next    = state;
      tx_byte_next  = tx_byte;
      grant_id_next = grant_id;
      case (state)
         IDLE: begin
            if (any_req && tx_idle) begin
               state_next    = ISSUE;
               tx_byte_next  = winner_byte;
               grant_id_next = winner;
            end
         end
         ISSUE:       state_next = WAIT_ACTIVE;
         WAIT_ACTIVE: if (i_Tx_Active) state_next = WAIT_DONE;
         WAIT_DONE:   if (i_Tx_Done) state_next = DRAIN;
         DRAIN:       if (tx_idle) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state    <= IDLE;
         tx_byte  <= 8'h00;
         grant_id <= 3'(NUM_REQ - 1);
      end else begin
         state    <= state_next;
         tx_byte  <= tx_byte_next;
         grant_id <= grant_id_next;
      end
   end

   always_comb begin
      o_Tx_DV    = (state == ISSUE);
      o_Req_Ack  = (state == ISSUE) ? grant_onehot : '0;
      o_Req_Done = (state == WAIT_DONE && i_Tx_Done) ? grant_onehot : '0;
      o_Busy     = (state != IDLE);
      o_Tx_Byte  = tx_byte;
      o_Grant_Id = grant_id;
      o_State    = state;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter and serial-frame receiver.
// Honours UART_ARB_FIXED_PRIO_EN for the expected grant orders.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CPB     = 4;
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;

   logic                   i_Clock = 1'b0;
   logic                   i_Rst_n;
   logic [NUM_REQ-1:0]     i_Req_DV;
   logic [8*NUM_REQ-1:0]   i_Req_Byte;
   logic [NUM_REQ-1:0]     o_Req_Ack;
   logic [NUM_REQ-1:0]     o_Req_Done;
   logic                   o_Tx_DV;
   logic [7:0]             o_Tx_Byte;
   logic [2:0]             o_Grant_Id;
   logic                   o_Busy;
   logic [2:0]             o_State;

   logic       tx_active = 1'b0;
   logic       tx_done   = 1'b0;
   int         tx_cnt    = 0;
   int         done_cyc  = 0;
   logic [9:0] frame     = 10'h3FF;
   logic [7:0] rx_sr     = 8'h00;
   logic       tx_serial;

   logic [7:0] sent_q[$];
   logic [7:0] exp_q[$];

   int ack_cnt[NUM_REQ];
   int done_cnt[NUM_REQ];
   int ack_s[NUM_REQ];
   int done_s[NUM_REQ];
   int dv_cnt     = 0;
   int dv_s       = 0;
   int dv_viol    = 0;
   int onehot_err = 0;
   int stab_err   = 0;
   logic [7:0] issued_byte = 8'h00;

   int tests = 0;
   int fails = 0;
   int rot_g[5];
   int dual_g[3];
   int dual_ack3;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .i_Clock     (i_Clock),
      .i_Rst_n     (i_Rst_n),
      .i_Req_DV    (i_Req_DV),
      .i_Req_Byte  (i_Req_Byte),
      .o_Req_Ack   (o_Req_Ack),
      .o_Req_Done  (o_Req_Done),
      .o_Tx_DV     (o_Tx_DV),
      .o_Tx_Byte   (o_Tx_Byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done),
      .o_Grant_Id  (o_Grant_Id),
      .o_Busy      (o_Busy),
      .o_State     (o_State)
   );

   // clock / watchdog
   always #5 i_Clock = ~i_Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // transmitter model: never reset, 10-bit frame then Done high for two cycles
   assign tx_serial = tx_active ? (((frame >> (tx_cnt / CPB)) & 10'd1) != 10'd0) : 1'b1;

   always @(posedge i_Clock) begin
      if (!tx_active && !tx_done) begin
         if (o_Tx_DV) begin
            tx_active <= 1'b1;
            tx_cnt    <= 0;
            frame     <= {1'b1, o_Tx_Byte, 1'b0};
         end
      end else if (tx_active) begin
         if ((tx_cnt % CPB) == CPB / 2 && tx_cnt >= CPB && tx_cnt < 9 * CPB)
            rx_sr <= {tx_serial, rx_sr[7:1]};
         if (tx_cnt == 10 * CPB - 1) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
            done_cyc  <= 0;
            sent_q.push_back(rx_sr);
         end
         tx_cnt <= tx_cnt + 1;
      end else begin
         done_cyc <= done_cyc + 1;
         if (done_cyc == 1) tx_done <= 1'b0;
      end
   end

   // protocol monitor
   always @(posedge i_Clock) begin
      for (int k = 0; k < NUM_REQ; k++) begin
         if (o_Req_Ack[k])  ack_cnt[k]  <= ack_cnt[k] + 1;
         if (o_Req_Done[k]) done_cnt[k] <= done_cnt[k] + 1;
      end
      if ($countones(o_Req_Ack) > 1 || $countones(o_Req_Done) > 1) onehot_err <= onehot_err + 1;
      if (o_Tx_DV) begin
         dv_cnt      <= dv_cnt + 1;
         issued_byte <= o_Tx_Byte;
         if (tx_active || tx_done) dv_viol <= dv_viol + 1;
      end else if (o_Busy && o_Tx_Byte !== issued_byte) begin
         stab_err <= stab_err + 1;
      end
   end

   // driver / checker tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      i_Rst_n = 1'b0;
      repeat (2) @(negedge i_Clock);
      i_Rst_n = 1'b1;
   endtask

   task automatic snap();
      for (int k = 0; k < NUM_REQ; k++) begin
         ack_s[k]  = ack_cnt[k];
         done_s[k] = done_cnt[k];
      end
      dv_s = dv_cnt;
   endtask

   task automatic wait_ack(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge i_Clock);
         n++;
      end while (o_Req_Ack == '0 && n < 300);
      check({tag, "_ack_timeout"}, 32'(o_Req_Ack != '0), 1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((o_Busy || tx_active || tx_done) && n < 300) begin
         @(negedge i_Clock);
         n++;
      end
      check({tag, "_idle_timeout"}, {o_Busy, tx_active, tx_done}, 0);
   endtask

   task automatic wait_state(input logic [2:0] st, input string tag);
      int n;
      n = 0;
      while (o_State !== st && n < 300) begin
         @(negedge i_Clock);
         n++;
      end
      check({tag, "_state_timeout"}, o_State, st);
   endtask

   // scoreboard: serial bytes seen on the line against expected queue
   task automatic check_sb(input string tag);
      logic [31:0] obs;
      logic [7:0]  e;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = (sent_q.size() > 0) ? 32'(sent_q.pop_front()) : 32'hDEAD;
         check(tag, obs, 32'(e));
      end
      check({tag, "_extra"}, sent_q.size(), 0);
   endtask

   // directed sequence
   initial begin
      i_Rst_n    = 1'b0;
      i_Req_DV   = '0;
      i_Req_Byte = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
      rot_g     = '{0, 0, 0, 0, 0};
      dual_g    = '{0, 0, 0};
      dual_ack3 = 0;
`else
      rot_g     = '{0, 1, 2, 3, 0};
      dual_g    = '{0, 3, 0};
      dual_ack3 = 1;
`endif
      repeat (3) @(negedge i_Clock);
      check("rst_tx_dv",  o_Tx_DV, 0);
      check("rst_byte",   o_Tx_Byte, 0);
      check("rst_ack",    o_Req_Ack, 0);
      check("rst_done",   o_Req_Done, 0);
      check("rst_busy",   o_Busy, 0);
      check("rst_gid",    o_Grant_Id, NUM_REQ - 1);
      check("rst_state",  o_State, ST_IDLE);
      i_Rst_n = 1'b1;

      // single request, byte 0x55
      snap();
      i_Req_Byte[7:0] = 8'h55;
      i_Req_DV        = 4'b0001;
      wait_ack("s1");
      check("s1_ack",   o_Req_Ack, 4'b0001);
      check("s1_tx_dv", o_Tx_DV, 1);
      check("s1_byte",  o_Tx_Byte, 8'h55);
      check("s1_gid",   o_Grant_Id, 0);
      i_Req_DV = '0;
      wait_idle("s1");
      check("s1_dv_cnt",   dv_cnt - dv_s, 1);
      check("s1_ack_cyc",  ack_cnt[0] - ack_s[0], 1);
      check("s1_done_cyc", done_cnt[0] - done_s[0], 1);
      check("s1_busy",     o_Busy, 0);
      exp_q.push_back(8'h55);
      check_sb("s1_frame");

      // all four held: rotation
      do_reset();
      snap();
      i_Req_Byte = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      i_Req_DV   = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_ack("s2");
         check("s2_gid", o_Grant_Id, rot_g[f]);
         check("s2_ack", o_Req_Ack, 32'(1) << rot_g[f]);
         exp_q.push_back(8'hA0 + 8'(rot_g[f]));
         if (f == 4) i_Req_DV = '0;
      end
      wait_idle("s2");
      check("s2_dv_cnt", dv_cnt - dv_s, 5);
      check_sb("s2_order");

      // wrap-around from last grant 3
      do_reset();
      i_Req_Byte = {8'h33, 8'h22, 8'h11, 8'h00};
      i_Req_DV   = 4'b1000;
      wait_ack("s3a");
      check("s3_gid_a", o_Grant_Id, 3);
      i_Req_DV = '0;
      wait_idle("s3a");
      i_Req_DV = 4'b1010;
      wait_ack("s3b");
      check("s3_wrap_gid",  o_Grant_Id, 1);
      check("s3_wrap_byte", o_Tx_Byte, 8'h11);
      i_Req_DV = 4'b1000;
      wait_ack("s3c");
      check("s3_gid_c", o_Grant_Id, 3);
      i_Req_DV = '0;
      wait_idle("s3c");
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h33);
      check_sb("s3_frames");

      // reset mid data bits of 0x3C while req2 is held
      do_reset();
      snap();
      i_Req_Byte = {8'h00, 8'h5A, 8'h00, 8'h3C};
      i_Req_DV   = 4'b0001;
      wait_ack("s4a");
      i_Req_DV = 4'b0100;
      begin
         int n;
         n = 0;
         while (!(tx_active && tx_cnt >= 5 * CPB) && n < 200) begin
            @(negedge i_Clock);
            n++;
         end
      end
      check("s4_midframe", tx_active, 1);
      i_Rst_n = 1'b0;
      @(negedge i_Clock);
      i_Rst_n = 1'b1;
      check("s4_rst_busy", o_Busy, 0);
      check("s4_rst_gid",  o_Grant_Id, 3);
      check("s4_rst_byte", o_Tx_Byte, 0);
      wait_ack("s4b");
      check("s4_gid",     o_Grant_Id, 2);
      check("s4_tx_idle", {tx_active, tx_done}, 0);
      check("s4_byte",    o_Tx_Byte, 8'h5A);
      i_Req_DV = '0;
      wait_idle("s4b");
      check("s4_no_done0", done_cnt[0] - done_s[0], 0);
      check("s4_done2",    done_cnt[2] - done_s[2], 1);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h5A);
      check_sb("s4_frames");

      // req1 pulsed during WAIT_DONE
      do_reset();
      snap();
      i_Req_Byte = {8'h00, 8'h00, 8'h99, 8'h77};
      i_Req_DV   = 4'b0001;
      wait_ack("s5");
      i_Req_DV = '0;
      wait_state(ST_WAIT_DONE, "s5");
      i_Req_DV = 4'b0010;
      repeat (3) @(negedge i_Clock);
      i_Req_DV = '0;
      check("s5_still_wait_done", o_State, ST_WAIT_DONE);
      wait_idle("s5");
      repeat (10) @(negedge i_Clock);
      check("s5_no_ack1", ack_cnt[1] - ack_s[1], 0);
      check("s5_dv_cnt",  dv_cnt - dv_s, 1);
      exp_q.push_back(8'h77);
      check_sb("s5_frames");

      // req0 and req3 held
      do_reset();
      snap();
      i_Req_Byte = {8'hD3, 8'h00, 8'h00, 8'hD0};
      i_Req_DV   = 4'b1001;
      for (int f = 0; f < 3; f++) begin
         wait_ack("s6");
         check("s6_gid", o_Grant_Id, dual_g[f]);
         exp_q.push_back(8'hD0 + 8'(dual_g[f]));
         if (f == 2) i_Req_DV = '0;
      end
      wait_idle("s6");
      check("s6_ack3", ack_cnt[3] - ack_s[3], dual_ack3);
      check_sb("s6_frames");

      check("onehot_violations",  onehot_err, 0);
      check("tx_dv_while_busy",   dv_viol, 0);
      check("tx_byte_stability",  stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
